// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, wait-state memory handshake and redirects
// Ports: clk/reset (sync, active-high); PCSrc + branch/jump/return targets from decode;
// stall from hazard unit; imem_req/imem_addr/imem_ready/imem_data memory handshake;
// inst_ID/PC_ID/valid_ID IF/ID register; fetch_busy high while a request is outstanding.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] branch_target,
  input  logic [15:0] jump_target,
  input  logic [15:0] return_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] inst_ID,
  output logic [15:0] PC_ID,
  output logic        valid_ID,
  output logic        fetch_busy
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DISCARD, HOLD} state_t;
  state_t state, state_nxt;
  logic [15:0] pc, req_addr, hold_word, target, word;
  logic redirect, accept;
  assign redirect = (PCSrc != 2'b00) & ~stall;
  assign target = PCSrc == 2'b01 ? branch_target : PCSrc == 2'b10 ? jump_target : return_addr;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   state_nxt = (stall | imem_ready) ? FETCH : redirect ? DISCARD : WAIT;
      WAIT:    state_nxt = imem_ready ? (stall ? HOLD : FETCH) : redirect ? DISCARD : WAIT;
      DISCARD: state_nxt = imem_ready ? FETCH : DISCARD;
      HOLD:    state_nxt = stall ? HOLD : FETCH;
      default: state_nxt = IDLE;
    endcase
  end
  // Outside FETCH the address comes from req_addr so it stays put across wait states,
  // even after a redirect has already moved pc on to the new target.
  always_comb begin
    imem_req = state == FETCH ? ~stall : (state == WAIT || state == DISCARD);
    imem_addr = state == FETCH ? pc : req_addr;
    fetch_busy = state == WAIT || state == DISCARD;
    word = state == HOLD ? hold_word : imem_data;
    accept = ~stall & ~redirect & (state == HOLD || ((state == FETCH || state == WAIT) && imem_ready));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      req_addr <= 16'h0000;
      hold_word <= 16'h0000;
      inst_ID <= NOP_INST;
      PC_ID <= 16'h0000;
      valid_ID <= 1'b0;
    end else begin
      if (redirect) pc <= target;
      else if (accept) pc <= imem_addr + 16'd1;
      if (state == FETCH && !stall) req_addr <= pc;
      if (state == WAIT && imem_ready && stall) hold_word <= imem_data;
      if (accept) begin
        inst_ID <= word;
        PC_ID <= imem_addr + 16'd1;
        valid_ID <= 1'b1;
      end else if (!stall) begin
        inst_ID <= NOP_INST;
        valid_ID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a transaction-level model of fetch_stage
module tb_fetch_stage;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP = 16'hF00F;
  logic clk = 1'b0;
  logic reset, stall, imem_ready, imem_req, valid_ID, fetch_busy;
  logic [1:0] PCSrc;
  logic [15:0] branch_target, jump_target, return_addr, imem_addr, imem_data, inst_ID, PC_ID;
  int total = 0;
  int passed = 0;
  bit m_started = 0, m_out = 0, m_drop = 0, m_held = 0, m_valid = 0;
  logic [15:0] m_pc = RST_PC, m_out_addr = 16'h0, m_hword = 16'h0, m_inst = NOP, m_pcid = 16'h0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .branch_target(branch_target),
    .jump_target(jump_target), .return_addr(return_addr), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .inst_ID(inst_ID), .PC_ID(PC_ID), .valid_ID(valid_ID),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    else passed++;
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs against the model,
  // then advance the model by what the coming rising edge must do.
  task automatic step(input bit rst, input bit stl, input logic [1:0] src, input bit rdy);
    logic [15:0] ea, d, a, w, tgt;
    bit ereq, rdy_a, redir, acc;
    ea = m_out ? m_out_addr : m_pc;
    ereq = m_started && !m_held && (m_out || !stl);
    rdy_a = rdy && (ereq || !m_started);
    d = (rdy_a && m_started) ? ea + 16'h1000 : 16'hBEEF;
    reset = rst; stall = stl; PCSrc = src; imem_ready = rdy_a; imem_data = d;
    #1;
    chk("imem_req", 16'(imem_req), 16'(ereq));
    if (ereq) chk("imem_addr", imem_addr, ea);
    chk("fetch_busy", 16'(fetch_busy), 16'(m_out));
    chk("inst_ID", inst_ID, m_inst);
    chk("PC_ID", PC_ID, m_pcid);
    chk("valid_ID", 16'(valid_ID), 16'(m_valid));
    if (rst) begin
      m_pc = RST_PC; m_started = 0; m_out = 0; m_drop = 0; m_held = 0;
      m_inst = NOP; m_pcid = 16'h0; m_valid = 0;
    end else begin
      redir = src != 2'b00 && !stl;
      tgt = src == 2'b01 ? branch_target : src == 2'b10 ? jump_target : return_addr;
      acc = 0; a = ea; w = d;
      if (!m_started) m_started = 1;
      else if (m_held) begin
        if (!stl) begin
          m_held = 0;
          if (!redir) begin acc = 1; w = m_hword; a = m_out_addr; end
        end
      end else if (m_out || !stl) begin
        if (rdy_a) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else if (stl) begin m_held = 1; m_hword = d; m_out_addr = a; end
          else if (!redir) acc = 1;
        end else begin
          m_out = 1; m_out_addr = a;
          if (redir) m_drop = 1;
        end
      end
      if (acc) begin m_inst = w; m_pcid = a + 16'd1; m_valid = 1; end
      else if (!stl) begin m_inst = NOP; m_valid = 0; end
      if (redir) m_pc = tgt;
      else if (acc) m_pc = a + 16'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; PCSrc = 2'b00; imem_ready = 0; imem_data = 16'h0;
    branch_target = 16'h0; jump_target = 16'h0; return_addr = 16'h0;
    @(negedge clk);
    step(0, 0, 2'b00, 1); step(0, 0, 2'b00, 1);
    chk("zw_inst0", inst_ID, 16'h1000); chk("zw_pc0", PC_ID, 16'h0001); chk("zw_v0", 16'(valid_ID), 16'h1);
    step(0, 0, 2'b00, 1);
    chk("zw_inst1", inst_ID, 16'h1001); chk("zw_pc1", PC_ID, 16'h0002);
    repeat (3) step(0, 0, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b00, 0);
      chk("wait_addr", imem_addr, 16'h0005); chk("wait_busy", 16'(fetch_busy), 16'h1);
      chk("wait_bubble", 16'(valid_ID), 16'h0);
    end
    step(0, 0, 2'b00, 1);
    chk("wait_inst", inst_ID, 16'h1005); chk("wait_pc", PC_ID, 16'h0006);
    branch_target = 16'h0040;
    step(0, 0, 2'b01, 1);
    chk("br_bubble", 16'(valid_ID), 16'h0); chk("br_nop", inst_ID, NOP); chk("br_addr", imem_addr, 16'h0040);
    step(0, 0, 2'b00, 1);
    branch_target = 16'h0009;
    step(0, 0, 2'b01, 1);
    step(0, 0, 2'b00, 0);
    jump_target = 16'h0200;
    step(0, 0, 2'b10, 0);
    step(0, 0, 2'b00, 0);
    chk("disc_addr", imem_addr, 16'h0009); chk("disc_busy", 16'(fetch_busy), 16'h1);
    step(0, 0, 2'b00, 1);
    chk("disc_bubble", 16'(valid_ID), 16'h0); chk("disc_nop", inst_ID, NOP); chk("disc_next", imem_addr, 16'h0200);
    step(0, 0, 2'b00, 0);
    step(0, 1, 2'b00, 1);
    chk("hold_req0", 16'(imem_req), 16'h0); chk("hold_v0", 16'(valid_ID), 16'h0);
    step(0, 1, 2'b00, 0);
    chk("hold_req1", 16'(imem_req), 16'h0); chk("hold_v1", 16'(valid_ID), 16'h0);
    step(0, 0, 2'b00, 0);
    chk("hold_inst", inst_ID, 16'h1200); chk("hold_pc", PC_ID, 16'h0201); chk("hold_v", 16'(valid_ID), 16'h1);
    jump_target = 16'hFFFF;
    step(0, 0, 2'b10, 1);
    step(0, 0, 2'b00, 1);
    chk("wrap_pc", PC_ID, 16'h0000); chk("wrap_inst", inst_ID, 16'h0FFF); chk("wrap_addr", imem_addr, 16'h0000);
    step(0, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0);
    chk("rst_inst", inst_ID, NOP); chk("rst_pc", PC_ID, 16'h0000); chk("rst_v", 16'(valid_ID), 16'h0);
    chk("rst_busy", 16'(fetch_busy), 16'h0); chk("rst_req", 16'(imem_req), 16'h0);
    step(0, 0, 2'b00, 1);
    step(0, 0, 2'b00, 1);
    chk("post_rst_inst", inst_ID, 16'h1000);
    for (int i = 0; i < 3000; i++) begin
      branch_target = 16'($urandom); jump_target = 16'($urandom); return_addr = 16'($urandom);
      step($urandom % 100 == 0, $urandom % 4 == 0,
           ($urandom % 7 == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'($urandom % 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
